fetch_prefetch_queue: RTL
=========================

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 imem_req_o  output  1  fetch request to instruction memory.
REQ-006 imem_addr_o  output  32  fetch address, word aligned.
REQ-007 imem_ack_i  input  1  memory completes the outstanding request this cycle.
REQ-008 imem_data_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-009 valid_o  output  1  head entry available to the CPU.
REQ-010 ready_i  input  1  CPU consumes the head entry this cycle.
REQ-011 instr_o  output  32  head instruction.
REQ-012 pc_o  output  32  address of the head instruction.
REQ-013 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc_i  input  32  new fetch address.
REQ-015 count_o  output  5  number of valid entries, 0..DEPTH.

Function
REQ-016 Three states SHALL exist: IDLE (no request outstanding), WAIT (request outstanding, result kept), SQUASH (request outstanding, result discarded).
REQ-017 At most one memory request SHALL be outstanding.
REQ-018 IDLE->WAIT when count_o<DEPTH and redirect_i=0; imem_req_o=1 and imem_addr_o=fetch PC from the following cycle.
REQ-019 imem_req_o and imem_addr_o SHALL stay constant while in WAIT or SQUASH until the edge where imem_ack_i=1.
REQ-020 imem_ack_i SHALL be ignored while imem_req_o=0.
REQ-021 WAIT, ack, no redirect: push {fetch PC, imem_data_i}, fetch PC += 4; if post-update count<DEPTH, stay WAIT with the new address (back-to-back requests), else go IDLE.
REQ-022 Fetch PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-023 Pop SHALL occur on the edge where valid_o=1 and ready_i=1; ready_i with valid_o=0 SHALL have no effect.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 valid_o SHALL equal (count_o!=0); instr_o and pc_o SHALL be 0 when valid_o=0.
REQ-026 Queue is never written when full (guaranteed by REQ-018/021); overflow and underflow SHALL be impossible.
REQ-027 Redirect SHALL flush all entries (count_o=0 next cycle), set fetch PC to {redirect_pc_i[31:2],2'b00}, and take priority over a same-cycle push and pop.
REQ-028 Redirect in IDLE: stay IDLE, request new PC next cycle. Redirect in WAIT without ack: go SQUASH. Redirect in WAIT with ack: data dropped, go IDLE.
REQ-029 SQUASH with ack: data dropped, go IDLE; further redirects in SQUASH only update fetch PC.
REQ-030 Latency: instruction acked on edge N SHALL appear on valid_o/instr_o after edge N (cycle N+1).

Reset
REQ-031 While rst_i=1: state IDLE, fetch PC=RESET_PC, count_o=0, valid_o=0, instr_o=0, pc_o=0, imem_req_o=0, imem_addr_o=RESET_PC.
REQ-032 Reset asserted mid-request SHALL abandon the request; a later stray ack SHALL be ignored per REQ-020.
REQ-033 First request SHALL be issued in the first cycle after rst_i deasserts.

Verification
REQ-034 Reset release, ack every cycle, ready_i=1 -> pc_o 0,4,8,12... one per cycle, instr_o matching memory.
REQ-035 DEPTH=4, ready_i=0, ack every cycle -> count_o reaches 4, imem_req_o drops, 4 requests total; raise ready_i -> req reissued at 0x10.
REQ-036 Ack latency 3 cycles, redirect to 0x40 in cycle 1 of WAIT -> SQUASH, acked word for old address dropped, next request address 0x40, count_o=0.
REQ-037 Full queue, same-cycle pop and redirect_pc_i=0x103 -> count_o=0, next imem_addr_o=0x100.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst_i asserted during WAIT, stray ack afterwards -> all outputs at reset values, no push.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Bundle of instruction-memory, CPU-side and redirect signals for the prefetch queue.
// The slave modport is the queue itself; the master modport is its environment.
interface fetch_prefetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [4:0]  count_o;

    modport slave (
        output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, count_o,
        input  imem_ack_i, imem_data_i, ready_i, redirect_i, redirect_pc_i
    );

    modport master (
        input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o, count_o,
        output imem_ack_i, imem_data_i, ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: keeps one memory fetch in flight and buffers up to DEPTH
// instructions with their PCs; a redirect flushes the queue and squashes the in-flight fetch.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    fetch_prefetch_queue_if.slave        bus
);
    localparam int unsigned   AW     = $clog2(DEPTH);
    localparam logic [4:0]    DepthC = 5'(DEPTH);
    localparam logic [AW-1:0] PtrOne = AW'(1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StSquash = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [4:0]    count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic          req_active;
    logic          ack;
    logic          push;
    logic          pop;
    logic          valid;
    logic [31:0]   pc_inc;
    logic [31:0]   redirect_pc;
    logic          unused_redirect_lsb;

    assign req_active  = (state_q != StIdle);
    assign ack         = req_active & bus.imem_ack_i;
    assign valid       = (count_q != 5'd0);
    assign push        = (state_q == StWait) & bus.imem_ack_i & ~bus.redirect_i;
    assign pop         = valid & bus.ready_i & ~bus.redirect_i;
    assign pc_inc      = pc_q + 32'd4;
    assign redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc_i[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (bus.redirect_i) begin
            count_d  = 5'd0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redirect_pc;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            count_d = count_q + {4'd0, push} - {4'd0, pop};
        end

        case (state_q)
            StIdle: begin
                if (!bus.redirect_i && (count_q < DepthC)) begin
                    state_d    = StWait;
                    req_addr_d = pc_q;
                end
            end
            StWait: begin
                if (ack) begin
                    if (bus.redirect_i) begin
                        state_d = StIdle;
                    end else begin
                        pc_d = pc_inc;
                        // Back-to-back fetch only while the post-update queue has room.
                        if (count_d < DepthC) begin
                            req_addr_d = pc_inc;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else if (bus.redirect_i) begin
                    state_d = StSquash;
                end
            end
            StSquash: begin
                if (ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 5'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_data_i;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    // In SQUASH the fetch PC may already hold the redirect target, so the bus address is latched.
    assign bus.imem_req_o  = req_active;
    assign bus.imem_addr_o = req_active ? req_addr_q : pc_q;
    assign bus.valid_o     = valid;
    assign bus.count_o     = count_q;
    assign bus.instr_o     = valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign bus.pc_o        = valid ? pc_mem_q[rd_ptr_q] : 32'd0;
endmodule
